// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-FF synchronized rxd, mid-bit sampling FSM, FWFT receive FIFO
// with sticky framing/overrun flags.
module uart_rx #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rxd,
  input  logic                          rd_en,
  output logic [7:0]                    dout,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          frame_err,
  output logic                          overrun,
  input  logic                          clr_err
);

  localparam int CPB = CLK_FREQ / BAUD;
  localparam int CW  = $clog2(CPB);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int NW  = AW + 1;
  localparam logic [CW-1:0] CNT_HALF = CW'(CPB / 2 - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(CPB - 1);
  localparam logic [NW-1:0] DEPTH_N  = NW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  logic          sync1_r;
  logic          rxs_r;
  state_t        state_r;
  logic [CW-1:0] cnt_r;
  logic [2:0]    idx_r;
  logic [7:0]    shreg_r;

  logic [7:0]    mem_r [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [NW-1:0] count_r;
  logic [7:0]    dout_r;
  logic          empty_r;
  logic          frame_err_r;
  logic          overrun_r;

  logic          stop_tick_s;
  logic          push_s;
  logic          frame_s;
  logic          full_s;
  logic          pop_s;
  logic          wr_s;
  logic          drop_s;
  logic [AW-1:0] rd_next_s;
  logic [NW-1:0] count_next_s;
  logic [7:0]    head_next_s;

  // Two-stage synchronizer for the asynchronous serial line (idle high)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_r <= 1'b1;
      rxs_r   <= 1'b1;
    end else begin
      sync1_r <= rxd;
      rxs_r   <= sync1_r;
    end
  end

  // Receive FSM: start qualification at half bit, then one sample per bit period
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
      idx_r   <= 3'd0;
      shreg_r <= 8'h00;
    end else begin
      case (state_r)
        ST_IDLE: begin
          cnt_r <= '0;
          if (!rxs_r) state_r <= ST_START;
          else        state_r <= ST_IDLE;
        end
        ST_START: begin
          if (cnt_r == CNT_HALF) begin
            cnt_r   <= '0;
            idx_r   <= 3'd0;
            state_r <= rxs_r ? ST_IDLE : ST_DATA;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        ST_DATA: begin
          if (cnt_r == CNT_FULL) begin
            cnt_r          <= '0;
            shreg_r[idx_r] <= rxs_r;
            if (idx_r == 3'd7) state_r <= ST_STOP;
            else               idx_r   <= idx_r + 3'd1;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        ST_STOP: begin
          // Re-arm at mid-stop so a back-to-back start edge is not missed
          if (cnt_r == CNT_FULL) begin
            cnt_r   <= '0;
            state_r <= ST_IDLE;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        default: begin
          cnt_r   <= '0;
          idx_r   <= 3'd0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // FIFO control decode; next head is precomputed so dout can be a register
  always_comb begin
    stop_tick_s  = (state_r == ST_STOP) && (cnt_r == CNT_FULL);
    push_s       = stop_tick_s && rxs_r;
    frame_s      = stop_tick_s && !rxs_r;
    full_s       = (count_r == DEPTH_N);
    pop_s        = rd_en && !empty_r;
    wr_s         = push_s && (!full_s || pop_s);
    drop_s       = push_s && full_s && !pop_s;
    rd_next_s    = pop_s ? (rd_ptr_r + AW'(1)) : rd_ptr_r;
    count_next_s = count_r;
    if (wr_s && !pop_s) begin
      count_next_s = count_r + NW'(1);
    end else if (pop_s && !wr_s) begin
      count_next_s = count_r - NW'(1);
    end else begin
      count_next_s = count_r;
    end
    if (count_next_s == '0) begin
      head_next_s = 8'h00;
    end else if (wr_s && (rd_next_s == wr_ptr_r)) begin
      head_next_s = shreg_r;
    end else begin
      head_next_s = mem_r[rd_next_s];
    end
  end

  // FIFO storage, pointers and registered head/level outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      dout_r   <= 8'h00;
      empty_r  <= 1'b1;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_r[i] <= 8'h00;
    end else begin
      if (wr_s) begin
        mem_r[wr_ptr_r] <= shreg_r;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      rd_ptr_r <= rd_next_s;
      count_r  <= count_next_s;
      dout_r   <= head_next_s;
      empty_r  <= (count_next_s == '0);
    end
  end

  // Sticky error flags; a fresh error outranks a simultaneous clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_err_r <= 1'b0;
      overrun_r   <= 1'b0;
    end else begin
      frame_err_r <= frame_s | (frame_err_r & ~clr_err);
      overrun_r   <= drop_s  | (overrun_r   & ~clr_err);
    end
  end

  assign dout      = dout_r;
  assign empty     = empty_r;
  assign count     = count_r;
  assign frame_err = frame_err_r;
  assign overrun   = overrun_r;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames are driven bit-serially, a queue model predicts
// FIFO contents and flags, and a monitor checks every pop against the queue head.
module tb_uart_rx;

  localparam int CLK_FREQ = 16;
  localparam int BAUD     = 1;
  localparam int DEPTH    = 16;
  localparam int CPB      = CLK_FREQ / BAUD;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rxd = 1'b1;
  logic       rd_en = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] dout;
  logic       empty;
  logic [4:0] count;
  logic       frame_err;
  logic       overrun;

  int         tests = 0;
  int         fails = 0;
  logic [7:0] exp_q[$];
  bit         exp_frame = 1'b0;
  bit         exp_ovr = 1'b0;
  logic [7:0] mon_b;

  always #5 clk = ~clk;

  uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .rxd(rxd), .rd_en(rd_en), .dout(dout), .empty(empty),
    .count(count), .frame_err(frame_err), .overrun(overrun), .clr_err(clr_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    tests++;
    if (act !== 32'(exp)) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, " count"}, 32'(count), exp_q.size());
    chk({tag, " empty"}, 32'(empty), (exp_q.size() == 0) ? 1 : 0);
    chk({tag, " dout"}, 32'(dout), (exp_q.size() == 0) ? 0 : int'(exp_q[0]));
    chk({tag, " frame_err"}, 32'(frame_err), int'(exp_frame));
    chk({tag, " overrun"}, 32'(overrun), int'(exp_ovr));
  endtask

  task automatic sample_pt();
    @(negedge clk);
    #4;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One 8N1 frame, one bit per CPB cycles; stop sample is 155 posedges after start drop
  task automatic send(input logic [7:0] b, input logic stop_bit, input bit pop_at_stop,
                      input int abort_at);
    logic [9:0] frame;
    frame = {stop_bit, b, 1'b0};
    for (int c = 0; c < 10 * CPB; c++) begin
      @(negedge clk);
      if (c == abort_at) begin
        reset = 1'b0;
        rxd   = 1'b1;
        rd_en = 1'b0;
        exp_q.delete();
        exp_frame = 1'b0;
        exp_ovr   = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        return;
      end
      rxd   = frame[c / CPB];
      rd_en = pop_at_stop && (c == 154);
      if (c == 154 && !pop_at_stop) begin
        #4;
        chk("pre-push count", 32'(count), exp_q.size());
      end
      if (c == 155) begin
        #4;
        if (stop_bit) begin
          if (exp_q.size() < DEPTH) exp_q.push_back(b);
          else exp_ovr = 1'b1;
        end else begin
          exp_frame = 1'b1;
        end
        check_state("post-stop");
      end
    end
    @(negedge clk);
    rxd = 1'b1;
    idle(20);
  endtask

  task automatic read_n(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rd_en = 1'b1;
    end
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic clear_flags();
    @(negedge clk);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    exp_frame = 1'b0;
    exp_ovr   = 1'b0;
  endtask

  // Monitor: every pop request is checked against the model queue head
  always begin
    @(negedge clk);
    #4;
    if (rd_en) begin
      if (exp_q.size() > 0) begin
        mon_b = exp_q.pop_front();
        chk("pop dout", 32'(dout), int'(mon_b));
        chk("pop empty", 32'(empty), 0);
      end else begin
        chk("pop on empty", 32'(empty), 1);
      end
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rb;
    logic       rstop;
    repeat (3) @(negedge clk);
    #4;
    check_state("reset");
    @(negedge clk);
    reset = 1'b1;
    idle(5);

    // Single byte, pop, then pop on empty
    send(8'h55, 1'b1, 1'b0, -1);
    sample_pt();
    check_state("t1");
    chk("t1 dout", 32'(dout), 8'h55);
    read_n(1);
    sample_pt();
    check_state("t1 popped");
    read_n(1);
    sample_pt();
    check_state("t1 empty pop");

    // Short low glitch on the line
    @(negedge clk);
    rxd = 1'b0;
    repeat (3) @(negedge clk);
    rxd = 1'b1;
    idle(40);
    sample_pt();
    check_state("t2 glitch");

    // Framing error and clear
    send(8'hA5, 1'b0, 1'b0, -1);
    sample_pt();
    check_state("t3 ferr");
    chk("t3 frame_err", 32'(frame_err), 1);
    clear_flags();
    sample_pt();
    check_state("t3 cleared");

    // Overflow: 17 bytes without reads
    for (int i = 0; i < 17; i++) send(8'(i), 1'b1, 1'b0, -1);
    sample_pt();
    check_state("t4 full");
    chk("t4 count", 32'(count), 16);
    chk("t4 overrun", 32'(overrun), 1);
    read_n(16);
    sample_pt();
    check_state("t4 drained");

    // Full FIFO with a pop in the push cycle
    clear_flags();
    for (int i = 0; i < 16; i++) send(8'($urandom), 1'b1, 1'b0, -1);
    send(8'($urandom), 1'b1, 1'b1, -1);
    sample_pt();
    check_state("t5 full");
    chk("t5 count", 32'(count), 16);
    chk("t5 overrun", 32'(overrun), 0);
    read_n(16);
    sample_pt();
    check_state("t5 drained");

    // Reset in the middle of data bit 4, then a clean frame
    send(8'h77, 1'b1, 1'b0, 88);
    idle(10);
    sample_pt();
    check_state("t6 reset");
    send(8'h3C, 1'b1, 1'b0, -1);
    sample_pt();
    chk("t6 dout", 32'(dout), 8'h3C);
    read_n(1);

    // Randomized traffic
    for (int k = 0; k < 25; k++) begin
      rb    = 8'($urandom);
      rstop = ($urandom_range(0, 9) != 0);
      send(rb, rstop, 1'b0, -1);
      if ($urandom_range(0, 4) == 0) clear_flags();
      read_n($urandom_range(0, 2));
      sample_pt();
      check_state("rand");
    end
    read_n(exp_q.size() + 1);
    sample_pt();
    check_state("final");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
